// File: rtl/pclk_rate_ctrl_pkg.sv
// pclk_rate_pkg: shared types and the rate-to-divider-ratio lookup for pclk_rate_ctrl.
package pclk_rate_pkg;

    typedef enum logic [2:0] {RUN, GATE, LOAD, HOLD, SETTLE, ACK} state_t;

    typedef logic [1:0] rate_t;

    localparam rate_t RATE_ILLEGAL = 2'd3;

    function automatic logic [7:0] rate_ratio(
        input rate_t      r,
        input logic [7:0] r0,
        input logic [7:0] r1,
        input logic [7:0] r2
    );
        return (r == 2'd0) ? r0 : (r == 2'd1) ? r1 : r2;
    endfunction

endpackage

// File: rtl/pclk_rate_ctrl.sv
// pclk_rate_ctrl: sequences Clock_Div through PIPE rate changes (gate, load, hold, settle, ack).
// Optional PCLK_RATE_LOCK_WAIT_EN adds div_lock and ends SETTLE early on lock, retrying LOAD on timeout.
module pclk_rate_ctrl
    import pclk_rate_pkg::*;
#(
    parameter logic [7:0] RATIO_R0      = 8'd20,
    parameter logic [7:0] RATIO_R1      = 8'd10,
    parameter logic [7:0] RATIO_R2      = 8'd5,
    parameter int         GATE_CYCLES   = 4,
    parameter int         HOLD_CYCLES   = 4,
    parameter int         SETTLE_CYCLES = 64
) (
    input  logic       Ref_Clk,
    input  logic       rst,
    input  logic       req_valid,
    input  rate_t      rate_req,
`ifdef PCLK_RATE_LOCK_WAIT_EN
    input  logic       div_lock,
`endif
    output logic       req_ready,
    output logic       rate_ack,
    output logic       rate_err,
    output rate_t      cur_rate,
    output logic [7:0] div_ratio,
    output logic       div_rst_n,
    output logic       clk_gate_en
);

    localparam logic [7:0] GATE_LD   = 8'(GATE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);

    state_t     r_state, w_state;
    logic [7:0] r_cnt, w_cnt;
    rate_t      r_tgt, w_tgt;
    rate_t      r_cur, w_cur;
    logic [7:0] r_ratio, w_ratio;
    logic       r_req, w_req;
    logic       r_gate, w_gate;
    logic       r_drst, w_drst;
    logic       r_ready, w_ready;
    logic       r_ack, w_ack;
    logic       r_err, w_err;
    logic       w_done, w_fail, w_accept;

`ifdef PCLK_RATE_LOCK_WAIT_EN
    logic r_lock;

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) r_lock <= 1'b0;
        else      r_lock <= div_lock;
    end

    // Lock must be seen on two consecutive samples, and only from the 4th settle cycle on
    assign w_done = div_lock && r_lock && ((SETTLE_LD - r_cnt) >= 8'd3);
    assign w_fail = (r_cnt == 8'd0) && !w_done;
`else
    assign w_done = (r_cnt == 8'd0);
    assign w_fail = 1'b0;
`endif

    assign w_accept = req_valid && r_ready;

    always_ff @(posedge Ref_Clk or negedge rst) begin
        if (!rst) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LD;
            r_tgt   <= 2'd0;
            r_cur   <= 2'd0;
            r_ratio <= RATIO_R0;
            r_req   <= 1'b0;
            r_gate  <= 1'b0;
            r_drst  <= 1'b0;
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_tgt   <= w_tgt;
            r_cur   <= w_cur;
            r_ratio <= w_ratio;
            r_req   <= w_req;
            r_gate  <= w_gate;
            r_drst  <= w_drst;
            r_ready <= w_ready;
            r_ack   <= w_ack;
            r_err   <= w_err;
        end
    end

    // Outputs are registered: each value below is what the next state presents on entry
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt - 8'd1;
        w_tgt   = r_tgt;
        w_cur   = r_cur;
        w_ratio = r_ratio;
        w_req   = r_req;
        w_gate  = r_gate;
        w_drst  = r_drst;
        w_ready = 1'b0;
        w_ack   = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            RUN: begin
                w_ready = !w_accept;
                if (w_accept) begin
                    if (rate_req == RATE_ILLEGAL) begin
                        w_err = 1'b1;
                    end else if (rate_req == r_cur) begin
                        w_ack = 1'b1;
                    end else begin
                        w_state = GATE;
                        w_cnt   = GATE_LD;
                        w_gate  = 1'b0;
                        w_tgt   = rate_req;
                        w_req   = 1'b1;
                    end
                end
            end
            GATE: begin
                if (r_cnt == 8'd0) begin
                    w_state = LOAD;
                    w_ratio = rate_ratio(r_tgt, RATIO_R0, RATIO_R1, RATIO_R2);
                    w_drst  = 1'b0;
                end
            end
            LOAD: begin
                w_state = HOLD;
                w_cnt   = HOLD_LD;
            end
            HOLD: begin
                if (r_cnt == 8'd0) begin
                    w_state = SETTLE;
                    w_cnt   = SETTLE_LD;
                    w_drst  = 1'b1;
                end
            end
            SETTLE: begin
                if (w_done) begin
                    w_state = ACK;
                    w_gate  = 1'b1;
                    w_cur   = r_tgt;
                    w_ack   = r_req;
                    w_req   = 1'b0;
                end else if (w_fail) begin
                    w_state = LOAD;
                    w_ratio = rate_ratio(r_tgt, RATIO_R0, RATIO_R1, RATIO_R2);
                    w_drst  = 1'b0;
                    w_err   = 1'b1;
                end
            end
            ACK: begin
                w_state = RUN;
                w_ready = 1'b1;
            end
            default: w_state = RUN;
        endcase
    end

    assign req_ready   = r_ready;
    assign rate_ack    = r_ack;
    assign rate_err    = r_err;
    assign cur_rate    = r_cur;
    assign div_ratio   = r_ratio;
    assign div_rst_n   = r_drst;
    assign clk_gate_en = r_gate;

endmodule

// File: tb/tb_pclk_rate_ctrl.sv
// tb_pclk_rate_ctrl: random rate requests against a timeline model; ack/err pulses go through a scoreboard queue.
`timescale 1ns/1ps
module tb_pclk_rate_ctrl;

    localparam int G = 4;
    localparam int H = 4;
    localparam int S = 64;

    logic       Ref_Clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] rate_req = 2'd0;
    logic       req_ready, rate_ack, rate_err, div_rst_n, clk_gate_en;
    logic [1:0] cur_rate;
    logic [7:0] div_ratio;

    pclk_rate_ctrl dut (
        .Ref_Clk    (Ref_Clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .rate_req   (rate_req),
        .req_ready  (req_ready),
        .rate_ack   (rate_ack),
        .rate_err   (rate_err),
        .cur_rate   (cur_rate),
        .div_ratio  (div_ratio),
        .div_rst_n  (div_rst_n),
        .clk_gate_en(clk_gate_en)
    );

    always #5 Ref_Clk = ~Ref_Clk;

    int cyc;
    always @(posedge Ref_Clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    typedef struct {
        bit         err;
        int         at;
        logic [1:0] cur;
        logic [7:0] ratio;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;

    // Model: the latest rate change started at cycle s_a; everything else follows from the fixed intervals
    int         s_a;
    logic [7:0] s_old, s_new;
    logic [1:0] m_cur, m_old;
    int         m_ready_at;
    bit         m_acc;

    function automatic logic [7:0] tbl(input logic [1:0] r);
        return (r == 2'd0) ? 8'd20 : (r == 2'd1) ? 8'd10 : 8'd5;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", n, cyc, act, exp);
        end
    endtask

    task automatic init_model();
        s_a        = -(G + 1);
        s_old      = 8'd20;
        s_new      = 8'd20;
        m_cur      = 2'd0;
        m_old      = 2'd0;
        m_ready_at = s_a + G + H + S + 2;
    endtask

    task automatic chk_reset();
        chk("rst_gate", clk_gate_en, 0);
        chk("rst_drst", div_rst_n, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_ack", rate_ack, 0);
        chk("rst_err", rate_err, 0);
        chk("rst_cur", cur_rate, 0);
        chk("rst_ratio", div_ratio, 20);
    endtask

    task automatic check_wave();
        int c;
        c = cyc;
        chk("gate", clk_gate_en, !(c >= s_a && c <= s_a + G + H + S));
        chk("drst", div_rst_n, !(c >= s_a + G && c <= s_a + G + H));
        chk("ratio", div_ratio, (c >= s_a + G) ? s_new : s_old);
        chk("cur", cur_rate, (c > s_a + G + H + S) ? m_cur : m_old);
        chk("ready", req_ready, c >= m_ready_at);
    endtask

    task automatic drive(input bit v, input logic [1:0] r);
        int a;
        req_valid = v;
        rate_req  = r;
        m_acc     = 1'b0;
        if (v && cyc >= m_ready_at) begin
            m_acc = 1'b1;
            a     = cyc + 1;
            if (r == 2'd3) begin
                q.push_back('{1'b1, a, m_cur, s_new});
                m_ready_at = a + 1;
            end else if (r == m_cur) begin
                q.push_back('{1'b0, a, m_cur, s_new});
                m_ready_at = a + 1;
            end else begin
                m_old = m_cur;
                m_cur = r;
                s_old = s_new;
                s_new = tbl(r);
                s_a   = a;
                q.push_back('{1'b0, a + G + H + S + 1, r, s_new});
                m_ready_at = a + G + H + S + 2;
            end
        end
    endtask

    task automatic step(input bit v, input logic [1:0] r);
        @(negedge Ref_Clk);
        check_wave();
        drive(v, r);
    endtask

    task automatic req_hold(input logic [1:0] r);
        int n;
        n = 0;
        do begin
            step(1'b1, r);
            n++;
        end while (!m_acc && n < 300);
        if (!m_acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout rate=%0d", r);
        end
        step(1'b0, 2'($urandom));
    endtask

    always @(negedge Ref_Clk) begin : monitor
        ev_t e;
        if (rst) begin
            if (q.size() != 0 && q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_pulse cyc=%0d want_at=%0d", cyc, q[0].at);
                void'(q.pop_front());
            end
            if (rate_ack || rate_err) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse cyc=%0d ack=%0b err=%0b", cyc, rate_ack, rate_err);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", rate_err, e.err);
                    chk("pulse_one_hot", rate_ack ^ rate_err, 1);
                    chk("pulse_cyc", cyc, e.at);
                    chk("pulse_cur", cur_rate, e.cur);
                    chk("pulse_ratio", div_ratio, e.ratio);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        init_model();
        #1 rst = 1'b0;
        repeat (3) @(negedge Ref_Clk);
        chk_reset();
        rst = 1'b1;
        repeat (75) step(1'b0, 2'd0);
        req_hold(2'd1);
        req_hold(2'd1);
        req_hold(2'd1);
        req_hold(2'd3);
        req_hold(2'd2);
        req_hold(2'd2);
        req_hold(2'd0);
        repeat (30) begin
            repeat ($urandom_range(0, 3)) step(1'b0, 2'($urandom));
            req_hold(2'($urandom_range(0, 3)));
        end
        req_hold(2'd0);
        req_hold(2'd2);
        while (cyc < s_a + G + 2) step(1'b0, 2'd1);
        #2 rst = 1'b0;
        #1 chk_reset();
        q.delete();
        repeat (3) @(negedge Ref_Clk);
        init_model();
        rst = 1'b1;
        repeat (80) step(1'b0, 2'd0);
        req_hold(2'd1);
        repeat (80) step(1'b0, 2'd0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover_pulses got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
